// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall/flush decisions, halt handling and
// retired-instruction / cycle counters for the five-stage core.
module pipe_ctrl #(
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_idx,
  input  logic             ex_is_jump,
  input  logic             ls_mem_req,
  input  logic             ls_mem_ready,
  input  logic             wb_valid,
  input  logic             wb_is_ebreak,
  output logic             pc_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             ls_stall,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             wb_flush,
  output logic             halted,
  output logic             halt_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  logic mw;
  logic ebreak_hit;
  logic timeout;
  logic redirect;
  logic rs1_hazard;
  logic rs2_hazard;
  logic load_use;
  logic halt_now;
  logic retire;

  // Hazard and event terms feeding the decision logic
  assign mw         = ls_mem_req & ~ls_mem_ready;
  assign ebreak_hit = (state == ST_RUN) & wb_valid & wb_is_ebreak;
  assign timeout    = (state == ST_MEMWAIT) & ~ls_mem_ready &
                      (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign redirect   = ex_valid & ex_is_jump;
  assign rs1_hazard = id_rs1_used & (id_rs1_idx == ex_rd_idx);
  assign rs2_hazard = id_rs2_used & (id_rs2_idx == ex_rd_idx);
  assign load_use   = ex_valid & ex_is_load & (ex_rd_idx != 5'd0) & id_valid &
                      (rs1_hazard | rs2_hazard);

  // Next state plus prioritised stall/flush outputs
  always_comb begin
    state_nxt = state;
    pc_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    ls_stall  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    wb_flush  = 1'b0;
    halt_now  = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (ebreak_hit) begin
          state_nxt = ST_HALT;
        end else if (mw) begin
          state_nxt = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        if (ls_mem_ready) begin
          state_nxt = ST_RUN;
        end else if (timeout) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    halt_now = (state == ST_HALT) | (state_nxt == ST_HALT);

    if (halt_now) begin
      pc_stall = 1'b1;
      id_stall = 1'b1;
      ex_stall = 1'b1;
      ls_stall = 1'b1;
      wb_flush = 1'b1;
    end else if (mw) begin
      // EX is frozen, so any jump or hazard simply re-presents after the wait
      pc_stall = 1'b1;
      id_stall = 1'b1;
      ex_stall = 1'b1;
      ls_stall = 1'b1;
      wb_flush = 1'b1;
    end else if (redirect) begin
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall = 1'b1;
      id_stall = 1'b1;
      ex_flush = 1'b1;
    end
  end

  // The ebreak still retires even though WB is flushed as the core halts
  assign retire = wb_valid & (~wb_flush | ebreak_hit);

  assign state_o = 2'(state);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Memory wait counter, restarted on each MEMWAIT entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == ST_RUN) && (state_nxt == ST_MEMWAIT)) begin
      wait_cnt <= '0;
    end else if ((state == ST_MEMWAIT) && !ls_mem_ready && !timeout) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Halt flags, captured on the edge that enters HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      halted   <= 1'b0;
      halt_err <= 1'b0;
    end else if ((state != ST_HALT) && (state_nxt == ST_HALT)) begin
      halted   <= 1'b1;
      halt_err <= timeout;
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
      if (state != ST_HALT) begin
        cycles <= cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a scoreboard of expected per-cycle outputs.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W       = 64;
  localparam int unsigned MEM_TIMEOUT = 4;

  // {pc_stall, id_stall, ex_stall, ls_stall, id_flush, ex_flush, wb_flush}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_JMP  = 7'b0000_110;
  localparam logic [6:0] C_MW   = 7'b1111_001;
  localparam logic [6:0] C_HLT  = 7'b1111_001;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1_idx;
  logic [4:0]       id_rs2_idx;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_valid;
  logic             ex_is_load;
  logic [4:0]       ex_rd_idx;
  logic             ex_is_jump;
  logic             ls_mem_req;
  logic             ls_mem_ready;
  logic             wb_valid;
  logic             wb_is_ebreak;
  logic             pc_stall;
  logic             id_stall;
  logic             ex_stall;
  logic             ls_stall;
  logic             id_flush;
  logic             ex_flush;
  logic             wb_flush;
  logic             halted;
  logic             halt_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] instret;
  logic [CNT_W-1:0] cycles;
  logic [6:0]       ctl_obs;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [1:0]       st;
    logic             hlt;
    logic             herr;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] cycles;
  } exp_t;

  exp_t             sb[$];
  int               n_checks;
  int               n_fail;
  logic [CNT_W-1:0] m_instret;
  logic [CNT_W-1:0] m_cycles;

  pipe_ctrl #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1_idx  (id_rs1_idx),
    .id_rs2_idx  (id_rs2_idx),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd_idx   (ex_rd_idx),
    .ex_is_jump  (ex_is_jump),
    .ls_mem_req  (ls_mem_req),
    .ls_mem_ready(ls_mem_ready),
    .wb_valid    (wb_valid),
    .wb_is_ebreak(wb_is_ebreak),
    .pc_stall    (pc_stall),
    .id_stall    (id_stall),
    .ex_stall    (ex_stall),
    .ls_stall    (ls_stall),
    .id_flush    (id_flush),
    .ex_flush    (ex_flush),
    .wb_flush    (wb_flush),
    .halted      (halted),
    .halt_err    (halt_err),
    .state_o     (state_o),
    .instret     (instret),
    .cycles      (cycles)
  );

  assign ctl_obs = {pc_stall, id_stall, ex_stall, ls_stall, id_flush, ex_flush, wb_flush};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    id_valid     = 1'b0;
    id_rs1_idx   = 5'd0;
    id_rs2_idx   = 5'd0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    ex_valid     = 1'b0;
    ex_is_load   = 1'b0;
    ex_rd_idx    = 5'd0;
    ex_is_jump   = 1'b0;
    ls_mem_req   = 1'b0;
    ls_mem_ready = 1'b0;
    wb_valid     = 1'b0;
    wb_is_ebreak = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [CNT_W-1:0] obs,
                          input logic [CNT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the current inputs, compare at the falling edge,
  // then advance the counter model across the rising edge.
  task automatic step(input string name, input logic [6:0] ctl, input logic [1:0] st,
                      input logic hlt, input logic herr, input logic ret);
    exp_t e;
    exp_t got;
    e.ctl     = ctl;
    e.st      = st;
    e.hlt     = hlt;
    e.herr    = herr;
    e.instret = m_instret;
    e.cycles  = m_cycles;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check_eq({name, ".ctl"},      CNT_W'(ctl_obs),  CNT_W'(got.ctl));
    check_eq({name, ".state"},    CNT_W'(state_o),  CNT_W'(got.st));
    check_eq({name, ".halted"},   CNT_W'(halted),   CNT_W'(got.hlt));
    check_eq({name, ".halt_err"}, CNT_W'(halt_err), CNT_W'(got.herr));
    check_eq({name, ".instret"},  instret,          got.instret);
    check_eq({name, ".cycles"},   cycles,           got.cycles);
    @(posedge clk);
    #1;
    if (got.st != 2'd2) m_cycles = m_cycles + CNT_W'(1);
    if (ret) m_instret = m_instret + CNT_W'(1);
    clear_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_cycles  = '0;
    m_instret = '0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_cycles  = '0;
    m_instret = '0;
    rst       = 1'b1;
    clear_in();
    @(posedge clk);
    do_reset();

    // Reset state
    step("reset", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Load-use on rs1 gives one bubble, then the bubble sits in EX
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd5;
    id_valid = 1; id_rs1_idx = 5'd5; id_rs1_used = 1; wb_valid = 1;
    step("lu.rs1", C_LU, 2'd0, 1'b0, 1'b0, 1'b1);
    id_valid = 1; id_rs1_idx = 5'd5; id_rs1_used = 1;
    step("lu.after", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);
    // Load-use via rs2
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd9;
    id_valid = 1; id_rs2_idx = 5'd9; id_rs2_used = 1; id_rs1_idx = 5'd9;
    step("lu.rs2", C_LU, 2'd0, 1'b0, 1'b0, 1'b0);
    // rd = x0 never hazards
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd0;
    id_valid = 1; id_rs1_idx = 5'd0; id_rs1_used = 1;
    step("lu.rd0", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);
    // Matching index but source not used
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd5;
    id_valid = 1; id_rs1_idx = 5'd5; id_rs1_used = 0; wb_valid = 1;
    step("lu.unused", C_NONE, 2'd0, 1'b0, 1'b0, 1'b1);
    // Not a load
    ex_valid = 1; ex_rd_idx = 5'd5;
    id_valid = 1; id_rs1_idx = 5'd5; id_rs1_used = 1;
    step("lu.noload", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);
    // ID empty
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd5;
    id_rs1_idx = 5'd5; id_rs1_used = 1;
    step("lu.idempty", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Jump beats load-use
    ex_valid = 1; ex_is_load = 1; ex_rd_idx = 5'd5; ex_is_jump = 1;
    id_valid = 1; id_rs1_idx = 5'd5; id_rs1_used = 1;
    step("jmp.lu", C_JMP, 2'd0, 1'b0, 1'b0, 1'b0);
    // Jump from an invalid EX slot is ignored
    ex_is_jump = 1;
    step("jmp.novalid", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Ready in the same cycle as request: no stall, no MEMWAIT
    ls_mem_req = 1; ls_mem_ready = 1; wb_valid = 1;
    step("mem.fast", C_NONE, 2'd0, 1'b0, 1'b0, 1'b1);
    // Three-cycle wait, with a jump pending in EX that must be ignored
    ls_mem_req = 1; ex_valid = 1; ex_is_jump = 1; wb_valid = 1;
    step("mem.w0", C_MW, 2'd0, 1'b0, 1'b0, 1'b0);
    ls_mem_req = 1; ex_valid = 1; ex_is_jump = 1;
    step("mem.w1", C_MW, 2'd1, 1'b0, 1'b0, 1'b0);
    ls_mem_req = 1; ex_valid = 1; ex_is_jump = 1;
    step("mem.w2", C_MW, 2'd1, 1'b0, 1'b0, 1'b0);
    // Ready releases everything in the same cycle; the jump now takes effect
    ls_mem_req = 1; ls_mem_ready = 1; ex_valid = 1; ex_is_jump = 1;
    step("mem.rdy", C_JMP, 2'd1, 1'b0, 1'b0, 1'b0);
    step("mem.back", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);
    // A second, longer wait must not time out early: the counter restarts
    for (int i = 0; i < 5; i++) begin
      ls_mem_req = 1;
      step("mem2.wait", C_MW, (i == 0) ? 2'd0 : 2'd1, 1'b0, 1'b0, 1'b0);
    end
    ls_mem_req = 1; ls_mem_ready = 1;
    step("mem2.rdy", C_NONE, 2'd1, 1'b0, 1'b0, 1'b0);
    step("mem2.back", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Ebreak after ten retirements; ebreak wins over a simultaneous memory wait
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1;
      step("eb.retire", C_NONE, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    wb_valid = 1; wb_is_ebreak = 1; ls_mem_req = 1;
    step("eb.hit", C_HLT, 2'd0, 1'b0, 1'b0, 1'b1);
    wb_valid = 1;
    step("eb.halt0", C_HLT, 2'd2, 1'b1, 1'b0, 1'b0);
    check_eq("eb.instret11", instret, CNT_W'(11));
    ls_mem_ready = 1; ls_mem_req = 1;
    step("eb.halt1", C_HLT, 2'd2, 1'b1, 1'b0, 1'b0);
    do_reset();
    step("eb.reset", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Timeout: MEM_TIMEOUT=4, ready never arrives
    do_reset();
    ls_mem_req = 1;
    step("to.enter", C_MW, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ls_mem_req = 1;
      step("to.wait", C_MW, 2'd1, 1'b0, 1'b0, 1'b0);
    end
    ls_mem_req = 1;
    step("to.halt0", C_HLT, 2'd2, 1'b1, 1'b1, 1'b0);
    check_eq("to.cycles6", cycles, CNT_W'(6));
    step("to.halt1", C_HLT, 2'd2, 1'b1, 1'b1, 1'b0);
    check_eq("to.cycles_frozen", cycles, CNT_W'(6));
    do_reset();
    step("to.reset", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of MEMWAIT
    ls_mem_req = 1;
    step("rw.enter", C_MW, 2'd0, 1'b0, 1'b0, 1'b0);
    ls_mem_req = 1;
    step("rw.wait", C_MW, 2'd1, 1'b0, 1'b0, 1'b0);
    do_reset();
    step("rw.reset", C_NONE, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RV64 core (PC → IF → ID → EX → LS → WB). It decides, every cycle, which pipeline registers hold, which are loaded with a bubble, and when the core halts. It resolves load-use hazards, jump/branch redirects, multi-cycle LS memory waits and `ebreak` termination. It also keeps retired-instruction and cycle counters for difftest and performance reporting.

## Interface
Parameters:
- `CNT_W`, default 64: width of the performance counters.
- `MEM_TIMEOUT`, default 255: maximum number of cycles in MEMWAIT before the block declares an error halt. Legal range 1..2^16-1.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `id_valid`  in  1  ID register holds a real instruction.
- `id_rs1_idx`, `id_rs2_idx`  in  5 each  source register indices decoded in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the instruction in ID actually reads that source.
- `ex_valid`  in  1  EX register holds a real instruction.
- `ex_is_load`  in  1  the instruction in EX is a load.
- `ex_rd_idx`  in  5  destination register of the instruction in EX.
- `ex_is_jump`  in  1  EX resolved a taken branch, `jal` or `jalr` this cycle.
- `ls_mem_req`  in  1  LS stage is presenting a memory access.
- `ls_mem_ready`  in  1  memory completes the LS access this cycle.
- `wb_valid`  in  1  WB register holds a real instruction.
- `wb_is_ebreak`  in  1  the instruction in WB is `ebreak`.
- `pc_stall`, `id_stall`, `ex_stall`, `ls_stall`  out  1 each  hold the corresponding register.
- `id_flush`, `ex_flush`, `wb_flush`  out  1 each  load a bubble into that register (valid=0, wben=0).
- `halted`  out  1  core has stopped.
- `halt_err`  out  1  the halt was caused by a memory timeout.
- `state_o`  out  2  current state: 0 RUN, 1 MEMWAIT, 2 HALT.
- `instret`  out  CNT_W  count of retired instructions.
- `cycles`  out  CNT_W  count of cycles spent outside HALT.

## Operation
States:
- **RUN**
  - Moves to MEMWAIT when `ls_mem_req & ~ls_mem_ready`.
  - Moves to HALT when `wb_valid & wb_is_ebreak`. This has priority over the MEMWAIT transition.
- **MEMWAIT**
  - Returns to RUN on `ls_mem_ready`.
  - Moves to HALT with `halt_err`=1 when the wait counter reaches `MEM_TIMEOUT` without `ls_mem_ready`.
- **HALT**
  - Absorbing; only `rst` leaves it.

Stall/flush decisions, evaluated combinationally in strict priority order:
1. **HALT**, or the cycle that enters HALT:
   - All four `*_stall`=1; `wb_flush`=1.
   - The `ebreak` itself retires: `instret` counts it once.
2. **Memory wait** (`mw = ls_mem_req & ~ls_mem_ready`, in RUN or MEMWAIT):
   - `pc_stall`, `id_stall`, `ex_stall`, `ls_stall`=1; `wb_flush`=1.
   - A jump or hazard pending in EX/ID is ignored this cycle. EX is frozen, so the jump re-presents itself after the wait.
3. **Redirect** (`ex_valid & ex_is_jump`):
   - `id_flush`=1, `ex_flush`=1; no stalls.
   - The PC loads the jump target.
   - Load-use is ignored because the ID instruction is squashed.
4. **Load-use** (`ex_valid & ex_is_load & ex_rd_idx!=0 & id_valid`, and an ID source that is used matches `ex_rd_idx`):
   - `pc_stall`=1, `id_stall`=1, `ex_flush`=1.
   - Exactly one bubble; forwarding from LS covers the following cycle.
5. **Otherwise**: all outputs 0.

Counters:
- `instret` += 1 on `wb_valid & ~wb_flush` (including the `ebreak` cycle).
- `cycles` += 1 every cycle while the state is not HALT.
- Both wrap modulo 2^CNT_W.
- Wait counter: cleared on entering MEMWAIT; increments each MEMWAIT cycle without `ls_mem_ready`.

## Timing
- Reset values: state RUN; `halted`=0, `halt_err`=0, `instret`=0, `cycles`=0, wait counter 0. All stall/flush outputs are 0 apart from their combinational dependence on inputs.
- Stall and flush outputs are combinational from inputs and state, with zero-cycle latency. State, counters, `halted` and `halt_err` are registered, so `halted` rises the cycle after the `ebreak` is seen in WB.
- Load-use: the bubble lasts exactly one cycle. The dependent instruction reaches EX two cycles after the load reached EX.
- Redirect: the target instruction enters ID one cycle after `ex_is_jump`.
- Memory: `ls_mem_ready` in the same cycle as `ls_mem_req` causes no stall and no MEMWAIT entry. `ls_mem_ready` while in MEMWAIT releases all stalls in that same cycle.
- Timeout: HALT with `halt_err`=1 is entered on the clock edge after the wait counter equals `MEM_TIMEOUT`.
- `rst` asserted in any state, including mid-MEMWAIT or HALT, returns everything to reset values on the next edge.

## Test plan
- **Load-use:** load `x5` in EX, ID reads `rs1`=5 → one cycle with `pc_stall`=`id_stall`=`ex_flush`=1, then all 0. Repeat with `rd`=0 or `rs1_used`=0 → no stall.
- **Jump:** `ex_is_jump`=1 together with a load-use match → `id_flush`=`ex_flush`=1 and `pc_stall`=0.
- **Memory wait:** `ls_mem_req`=1 with `ls_mem_ready` low for 3 cycles → `state_o`=1 and all stalls plus `wb_flush` asserted for exactly 3 cycles; back to RUN on ready.
- **Timeout:** `MEM_TIMEOUT`=4, `ls_mem_ready` never rises → `halted`=1, `halt_err`=1, `state_o`=2; `cycles` stops incrementing.
- **Ebreak:** after 10 retirements, `wb_valid & wb_is_ebreak` → `instret`=11, `halted`=1 next cycle, all stalls held. Asserting `rst` then returns state RUN and counters to 0.
